// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch time base: FSM encoding, digit
// positions, reset constants for the display side-band outputs and the
// BCD digit increment helper.
package stopwatch_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_LAP  = 2'd3
  } sw_state_e;

  // Digit positions inside the display word (digit n occupies [4n+3:4n]).
  localparam int DIG_HUND  = 0;
  localparam int DIG_TENTH = 1;
  localparam int DIG_SEC_U = 2;
  localparam int DIG_SEC_T = 3;
  localparam int DIG_MIN_U = 4;
  localparam int DIG_MIN_T = 5;
  localparam int DIG_HR_U  = 6;
  localparam int DIG_HR_T  = 7;

  localparam logic [NUM_DIGITS-1:0] DP_RST  = 8'b0001_0100;
  localparam logic [NUM_DIGITS-1:0] DEN_RST = 8'b0011_1111;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] bcd_t;

  // Largest legal value of each digit; tens of seconds/minutes stop at 5.
  function automatic logic [DIGIT_W-1:0] dig_max(input int pos);
    case (pos)
      DIG_SEC_T, DIG_MIN_T: dig_max = 4'd5;
      DIG_HUND, DIG_TENTH, DIG_SEC_U, DIG_MIN_U, DIG_HR_U, DIG_HR_T: dig_max = 4'd9;
      default: dig_max = 4'd9;
    endcase
  endfunction

  // Returns {carry, next_digit}; anything at or above the limit wraps to 0
  // so a digit can never escape its range.
  function automatic logic [DIGIT_W:0] bcd_digit_inc(input logic [DIGIT_W-1:0] d,
                                                     input logic [DIGIT_W-1:0] lim);
    if (d >= lim) return {1'b1, {DIGIT_W{1'b0}}};
    return {1'b0, DIGIT_W'(d + 1'b1)};
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw push-button conditioner: 2-FF synchronizer, stability counter, and a
// one-cycle press pulse on each accepted 0->1 transition.
module button_debouncer #(
  parameter int CLOCK_FREQ  = 100000000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam longint DB_L   = longint'(DEBOUNCE_MS) * longint'(CLOCK_FREQ) / 64'sd1000;
  localparam int     DB_CYC = (DB_L < 1) ? 1 : int'(DB_L);
  localparam int     CNT_W  = $clog2(DB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic             prev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             samp;

  assign samp  = sync_q[1];
  assign press = press_q;

  // Accept the synchronized level only after it has differed from the
  // accepted level for DB_CYC consecutive cycles.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (samp != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = samp;
      else                   cnt_d    = cnt_q + 1'b1;
    end
  end

  // Synchronizer, debounce state and registered rising-edge pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn_raw};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      prev_q   <= stable_q;
      press_q  <= stable_q & ~prev_q;
    end
  end

endmodule

// File: rtl/stopwatch_timebase.sv
// Stopwatch time base: debounced buttons, start/stop/lap/clear FSM,
// 10 ms prescaler and BCD HH:MM:SS.hh count feeding the 7-segment driver.
// Optional lap-freeze display is built when STOPWATCH_LAP_EN is defined.
module stopwatch_timebase
  import stopwatch_pkg::*;
#(
  parameter int CLOCK_FREQ  = 100000000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start_stop,
  input  logic        btn_lap_clear,
  output logic [31:0] display,
  output logic [7:0]  dp_bitmap,
  output logic [7:0]  digit_enable,
  output logic        running
);

  localparam int TICK_DIV = (CLOCK_FREQ / 100 < 1) ? 1 : CLOCK_FREQ / 100;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic start_p, lap_p;

  button_debouncer #(.CLOCK_FREQ(CLOCK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_db_start (
    .clk(clk), .reset(reset), .btn_raw(btn_start_stop), .press(start_p)
  );

  button_debouncer #(.CLOCK_FREQ(CLOCK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_db_lap (
    .clk(clk), .reset(reset), .btn_raw(btn_lap_clear), .press(lap_p)
  );

  sw_state_e        state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  bcd_t             cnt_q, cnt_d;
  bcd_t             disp_src;
  logic             counting, tick, clr;
  logic             carry;
  logic [DIGIT_W:0] inc;
  logic [31:0]      display_q;
  logic [7:0]       dp_q, dp_d, den_q, den_d;
  logic             running_q;
  logic             hr_nz;

  assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign tick     = counting && (pre_q == PRE_LAST);

`ifdef STOPWATCH_LAP_EN
  logic lap_cap;
  bcd_t lap_q, lap_d;
`endif

  // Next-state logic; start always wins over a same-cycle lap press.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_cap = 1'b0;
`endif
    case (state_q)
      ST_IDLE: if (start_p) state_d = ST_RUN;
      ST_RUN: begin
        if (start_p) state_d = ST_STOP;
`ifdef STOPWATCH_LAP_EN
        else if (lap_p) begin
          state_d = ST_LAP;
          lap_cap = 1'b1;
        end
`endif
      end
      ST_STOP: begin
        if (start_p) state_d = ST_RUN;
        else if (lap_p) begin
          state_d = ST_IDLE;
          clr     = 1'b1;
        end
      end
      ST_LAP: begin
`ifdef STOPWATCH_LAP_EN
        if (start_p)    state_d = ST_STOP;
        else if (lap_p) state_d = ST_RUN;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Prescaler: free-runs while counting, frozen in STOP, zeroed in IDLE.
  always_comb begin
    pre_d = pre_q;
    if (state_q == ST_IDLE || clr) pre_d = '0;
    else if (counting)             pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // Ripple-carry BCD increment on tick; the hours-tens carry out is dropped.
  always_comb begin
    cnt_d = cnt_q;
    carry = tick;
    inc   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      inc = bcd_digit_inc(cnt_q[i], dig_max(i));
      if (carry) begin
        cnt_d[i] = inc[DIGIT_W-1:0];
        carry    = inc[DIGIT_W];
      end
    end
    if (clr) cnt_d = '0;
  end

`ifdef STOPWATCH_LAP_EN
  // Lap capture takes the post-tick value so the frozen view is seamless.
  always_comb begin
    lap_d = lap_q;
    if (lap_cap) lap_d = cnt_d;
  end

  // Lap freeze register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lap_q <= '0;
    else       lap_q <= lap_d;
  end

  assign disp_src = (state_q == ST_LAP) ? lap_q : cnt_q;
`else
  assign disp_src = cnt_q;
`endif

  // Blanking and decimal points follow the digits actually shown.
  always_comb begin
    hr_nz           = |{disp_src[DIG_HR_T], disp_src[DIG_HR_U]};
    den_d           = DEN_RST;
    den_d[DIG_HR_T] = |disp_src[DIG_HR_T];
    den_d[DIG_HR_U] = hr_nz;
    dp_d            = DP_RST;
    dp_d[DIG_HR_U]  = hr_nz;
  end

  // Core state: FSM, prescaler, live count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs, one cycle behind the count/state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      display_q <= '0;
      dp_q      <= DP_RST;
      den_q     <= DEN_RST;
      running_q <= 1'b0;
    end else begin
      display_q <= disp_src;
      dp_q      <= dp_d;
      den_q     <= den_d;
      running_q <= counting;
    end
  end

  assign display      = display_q;
  assign dp_bitmap    = dp_q;
  assign digit_enable = den_q;
  assign running      = running_q;

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Bench for stopwatch_timebase with CLOCK_FREQ=1000, DEBOUNCE_MS=1.
// The model tracks elapsed time as an integer count of hundredths and
// converts it to digits arithmetically; honours STOPWATCH_LAP_EN.
module tb_stopwatch_timebase;

  localparam int CF     = 1000;
  localparam int DBMS   = 1;
  localparam int N      = CF / 100;          // cycles per hundredth
  localparam int L      = 3 + DBMS * CF / 1000; // raw edge -> visible press
  localparam int T_WRAP = 100 * 360000;      // 100 hours in hundredths
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_LAP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_start_stop = 1'b0;
  logic        btn_lap_clear = 1'b0;
  logic [31:0] display;
  logic [7:0]  dp_bitmap, digit_enable;
  logic        running;

  stopwatch_timebase #(.CLOCK_FREQ(CF), .DEBOUNCE_MS(DBMS)) dut (
    .clk(clk), .reset(reset),
    .btn_start_stop(btn_start_stop), .btn_lap_clear(btn_lap_clear),
    .display(display), .dp_bitmap(dp_bitmap),
    .digit_enable(digit_enable), .running(running)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  // model state
  int   st_m = M_IDLE;
  int   T_m = 0, lapT_m = 0, act_m = 0, srcT_m = 0;
  logic run_m = 1'b0;
  logic [15:0] hs = '0, hl = '0;
  logic ps_v = 1'b0, pl_v = 1'b0;
  logic [31:0] pl_val = '0;

  function automatic logic [31:0] bcd(input int t);
    int hh, mm, ss, cc;
    hh = t / 360000;
    mm = (t / 6000) % 60;
    ss = (t / 100) % 60;
    cc = t % 100;
    bcd = {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
           4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic logic [7:0] de_of(input int t);
    int hh;
    hh = t / 360000;
    de_of = {hh >= 10, hh >= 1, 6'h3F};
  endfunction

  function automatic logic [7:0] dp_of(input int t);
    dp_of = {1'b0, t / 360000 >= 1, 6'b010100};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_step();
    int old_st;
    if (reset) begin
      st_m = M_IDLE; T_m = 0; lapT_m = 0; act_m = 0; srcT_m = 0; run_m = 1'b0;
      hs = '0; hl = '0; ps_v = 1'b0; pl_v = 1'b0;
      return;
    end
    old_st = st_m;
    srcT_m = (old_st == M_LAP) ? lapT_m : T_m;
    run_m  = (old_st == M_RUN) || (old_st == M_LAP);
    if (run_m) begin
      act_m++;
      if (act_m % N == 0) T_m = (T_m + 1) % T_WRAP;
    end else if (old_st == M_IDLE) act_m = 0;
    if (ps_v) begin
      case (old_st)
        M_IDLE: st_m = M_RUN;
        M_RUN:  st_m = M_STOP;
        M_STOP: st_m = M_RUN;
        M_LAP:  st_m = M_STOP;
        default: st_m = M_IDLE;
      endcase
    end else if (pl_v) begin
      case (old_st)
`ifdef STOPWATCH_LAP_EN
        M_RUN: begin st_m = M_LAP; lapT_m = T_m; end
        M_LAP: st_m = M_RUN;
`endif
        M_STOP: begin st_m = M_IDLE; T_m = 0; end
        default: st_m = old_st;
      endcase
    end
    hs = {hs[14:0], btn_start_stop};
    hl = {hl[14:0], btn_lap_clear};
    ps_v = hs[L-1] & ~hs[L];
    pl_v = hl[L-1] & ~hl[L];
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !reset) begin
        chk("cyc_display", display, bcd(srcT_m));
        chk("cyc_digit_enable", {24'b0, digit_enable}, {24'b0, de_of(srcT_m)});
        chk("cyc_dp_bitmap", {24'b0, dp_bitmap}, {24'b0, dp_of(srcT_m)});
        chk("cyc_running", {31'b0, running}, {31'b0, run_m});
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic s, input logic l);
    btn_start_stop = s;
    btn_lap_clear  = l;
    repeat (4) cyc();
    btn_start_stop = 1'b0;
    btn_lap_clear  = 1'b0;
    repeat (4) cyc();
  endtask

  // Overwrite the live count in the DUT and the model together.
  task automatic preload(input int t);
    pl_val = bcd(t);
    T_m = t;
    force dut.cnt_q = pl_val;
    #1;
    release dut.cnt_q;
  endtask

  task automatic wait_T(input int tgt, input int budget, input string nm);
    int k;
    k = 0;
    while (T_m != tgt && k < budget) begin
      cyc();
      k++;
    end
    if (T_m != tgt) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: model count %0d never reached %0d", nm, T_m, tgt);
    end
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    repeat (3) cyc();
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (100) cyc();
    chk("rst_display", display, 32'h0);
    chk("rst_digit_enable", {24'b0, digit_enable}, 32'h3F);
    chk("rst_dp_bitmap", {24'b0, dp_bitmap}, 32'h14);
    chk("rst_running", {31'b0, running}, 32'h0);

    // start, reach 1.00 s, stop and hold
    press(1'b1, 1'b0);
    chk("run_after_start", {31'b0, running}, 32'h1);
    wait_T(100, 1200, "reach_1s");
    press(1'b1, 1'b0);
    repeat (200) cyc();
    chk("stop_frozen_display", display, 32'h0000_0100);
    chk("stop_running", {31'b0, running}, 32'h0);

    // resume, minute carry, full wrap
    press(1'b1, 1'b0);
    preload(5999);
    wait_T(6000, 20, "minute_carry");
    cyc();
    chk("minute_carry_display", display, 32'h0001_0000);
    preload(35999999);
    wait_T(0, 20, "full_wrap");
    cyc();
    chk("wrap_display", display, 32'h0);
    chk("wrap_running", {31'b0, running}, 32'h1);

    // hour blanking
    preload(360000);
    repeat (2) cyc();
    chk("hr1_digit_enable", {24'b0, digit_enable}, 32'h7F);
    chk("hr1_dp_bitmap", {24'b0, dp_bitmap}, 32'h54);
    preload(3600000);
    repeat (2) cyc();
    chk("hr10_digit_enable", {24'b0, digit_enable}, 32'hFF);
    chk("hr10_dp_bitmap", {24'b0, dp_bitmap}, 32'h54);

    // stop then clear
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("clear_display", display, 32'h0);
    chk("clear_running", {31'b0, running}, 32'h0);
    chk("clear_digit_enable", {24'b0, digit_enable}, 32'h3F);

    // lap behaviour
    press(1'b1, 1'b0);
    wait_T(50, 700, "reach_half_s");
    press(1'b0, 1'b1);
`ifdef STOPWATCH_LAP_EN
    repeat (298) cyc();
    chk("lap_frozen_display", display, 32'h0000_0050);
    chk("lap_model_live", T_m, 32'd80);
    chk("lap_running", {31'b0, running}, 32'h1);
    press(1'b0, 1'b1);
    chk("lap_exit_running", {31'b0, running}, 32'h1);
`else
    repeat (293) cyc();
    chk("lap_ignored_display", display, 32'h0000_0080);
    chk("lap_ignored_running", {31'b0, running}, 32'h1);
`endif

    // simultaneous start+lap in STOP: start wins, count kept
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    chk("both_running", {31'b0, running}, 32'h1);
    chk("both_not_cleared", {31'b0, display != 32'h0}, 32'h1);

    // asynchronous reset mid-run
    repeat (20) cyc();
    reset = 1'b1;
    #1;
    chk("async_rst_display", display, 32'h0);
    chk("async_rst_digit_enable", {24'b0, digit_enable}, 32'h3F);
    chk("async_rst_dp_bitmap", {24'b0, dp_bitmap}, 32'h14);
    chk("async_rst_running", {31'b0, running}, 32'h0);
    repeat (2) cyc();
    reset = 1'b0;
    repeat (30) cyc();
    chk("post_rst_display", display, 32'h0);
    chk("post_rst_running", {31'b0, running}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_timebase.md
# stopwatch_timebase

Upstream time-keeping stage of the stopwatch: takes two raw push-buttons, debounces them, runs a start/stop/lap/clear state machine, and keeps an 8-digit BCD HH:MM:SS.hh count advanced every 10 ms. It produces the `display` word, `dp_bitmap`, and `digit_enable` inputs consumed directly by the seven-segment driver. All outputs are registered.

## Interface
- `CLOCK_FREQ`, default 100000000: clk frequency in Hz.
- `DEBOUNCE_MS`, default 10: time in ms a button level must stay stable before it is accepted.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `btn_start_stop`  in  1: raw, asynchronous start/stop button; high = pressed.
- `btn_lap_clear`  in  1: raw, asynchronous lap/clear button; high = pressed.
- `display`  out  32: BCD digits. [31:28]=H tens, [27:24]=H units, [23:20]=M tens, [19:16]=M units, [15:12]=S tens, [11:8]=S units, [7:4]=tenths, [3:0]=hundredths.
- `dp_bitmap`  out  8: decimal-point enables, bit n = digit n.
- `digit_enable`  out  8: digit enables, bit n = digit n; used for leading-hour blanking.
- `running`  out  1: high while the count advances (states RUN, LAP).

## Operation
- **Debounce.**
  - Each button passes through a 2-FF synchronizer, then a stability counter of DEBOUNCE_MS*CLOCK_FREQ/1000 cycles.
  - The accepted level rising 0→1 emits a one-cycle press pulse. Release produces nothing.
- **Prescaler.**
  - Counts 0..CLOCK_FREQ/100-1 and emits `tick` on the terminal value.
  - Advances only in RUN and LAP. Holds its value in STOP. Cleared to 0 in IDLE.
- **BCD count.** On `tick`, hundredths increments with a ripple carry:
  - hundredths and tenths wrap 9→0;
  - seconds and minutes wrap 59→00;
  - hours wrap 99→00.
  - 99:59:59.99 + tick = 00:00:00.00, and counting continues.
  - Digits never leave 0–9 / 0–5 ranges.
- **FSM states:** IDLE, RUN, STOP, LAP.
  - IDLE: start → RUN; lap → IDLE (no effect).
  - RUN: start → STOP; lap → LAP.
  - LAP: start → STOP (display shows live count); lap → RUN.
  - STOP: start → RUN (resume); lap → IDLE, clearing the count and prescaler.
- **Simultaneous events.**
  - Start and lap pulses in the same cycle: start wins, lap is discarded.
  - A press coinciding with `tick`: the tick is applied using the pre-transition state's counting rule.
- **Display source.**
  - LAP: `display` holds the count captured on entry to LAP while the live count keeps running.
  - All other states: `display` follows the live count.
- **Blanking and decimal points.**
  - digit_enable[7] = H tens ≠ 0.
  - digit_enable[6] = hours ≠ 00.
  - digit_enable[5:0] = all ones.
  - dp_bitmap[6] = digit_enable[6]; dp_bitmap[4] = dp_bitmap[2] = 1; all other bits 0.

## Timing
- **Reset values:**
  - `display` = 32'h0000_0000
  - `dp_bitmap` = 8'b0001_0100
  - `digit_enable` = 8'b0011_1111
  - `running` = 0
  - FSM = IDLE; prescaler, count, and debouncers cleared.
- **Reset mid-operation** returns to these values immediately (asynchronous), whatever the state.
- **Press latency:** raw edge → press pulse = 2 sync cycles + debounce count + 1.
- **State change:** the state changes on the clock after the pulse; `running` follows 1 cycle later.
- **Tick latency:** live count updates on the clock edge with `tick` high. `display`, `dp_bitmap`, and `digit_enable` update exactly 1 cycle after the count.
- **Start to first increment:** from IDLE, the first hundredth increment occurs CLOCK_FREQ/100 cycles after entering RUN.

## Configuration
- Macro: `STOPWATCH_LAP_EN`.
- **Defined:** LAP state and lap-freeze register exist, behaving as above.
- **Undefined:**
  - LAP state and freeze register are removed.
  - Lap in RUN is ignored.
  - Lap in STOP still clears to IDLE.
  - `display` always follows the live count.

## Structure
- **Package `stopwatch_pkg`:**
  - FSM state encoding (IDLE=0, RUN=1, STOP=2, LAP=3);
  - digit bit-position constants;
  - reset constants for `dp_bitmap` and `digit_enable`;
  - BCD digit width (4).
- **Sub-module `button_debouncer`** (params CLOCK_FREQ, DEBOUNCE_MS; ports clk, reset, btn_raw, press), instantiated twice.

## Test plan
Run with CLOCK_FREQ=1000 and DEBOUNCE_MS=1: tick every 10 cycles, debounce 1 cycle.
- Reset, then idle 100 cycles → `display`=0, `digit_enable`=8'h3F, `dp_bitmap`=8'h14, `running`=0.
- Start press, run 1000 cycles → `display`=32'h0000_0100 (1.00 s); start again → value frozen over a further 200 cycles.
- Preload count to 32'h0000_5999 in RUN, one tick → 32'h0001_0000; preload 99:59:59.99, one tick → 0, still running.
- Hours reach 01 → `digit_enable`=8'h7F, `dp_bitmap`=8'h54; hours 10 → `digit_enable`=8'hFF.
- With LAP_EN: lap pressed at 0.50 s → `display` holds 32'h0000_0050 for 300 cycles while live count reaches 0.80 s; lap again → `display` shows live count.
- In STOP, press start and lap in the same cycle → RUN resumes with the count not cleared; in STOP, lap alone → IDLE and `display`=0.
